ysyx_25040129_lsu_rd_master: RTL
================================

// Module: ysyx_25040129_lsu_rd_master
// PURPOSE
//  Read-channel initiator between the LSU load path and the memory-mapped read bus
//  (AR/R, OKAY/SLVERR/DECERR). Devices such as the CLINT respond on the far end.
//  Accepts one load request at a time and checks alignment. Drives AR, then R.
//  Extracts and sign- or zero-extends the addressed lane, and returns the result
//  with an error flag. A cycle timeout stops the core from hanging on a silent device.
// PARAMETERS
//  TIMEOUT  1023  cycles from request accept to error if rvalid never arrives (>=4)
//  TO_W     10    counter width, must satisfy 2**TO_W > TIMEOUT
// PORTS
//  clk        in   1   clock, all flops on posedge
//  rst        in   1   reset, asynchronous, active-low (0 = in reset)
//  req_valid  in   1   load request valid
//  req_ready  out  1   request accepted when req_valid & req_ready
//  req_addr   in   32  byte address
//  req_size   in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_signed in   1   1 = sign-extend, 0 = zero-extend
//  rsp_valid  out  1   response valid, held until rsp_ready
//  rsp_ready  in   1   core accepts response
//  rsp_data   out  32  extended load data (0 when rsp_err)
//  rsp_err    out  1   misaligned/illegal, rresp!=OKAY, or timeout
//  rsp_to     out  1   qualifies rsp_err: error was a timeout
//  araddr     out  32  read address (latched req_addr, unmodified)
//  arvalid    out  1   read address valid
//  arready    in   1   slave accepts address
//  rdata      in   32  read data
//  rresp      in   2   read response
//  rvalid     in   1   read data valid
//  rready     out  1   master accepts data
// BEHAVIOUR
//  Reset (rst=0, any state, mid-transaction included): state goes to IDLE at once.
//   arvalid=0, rready=0, rsp_valid=0, rsp_data=0, rsp_err=0, rsp_to=0, araddr=0.
//   Counter=0. req_ready=1 in IDLE.
//  FSM with states IDLE, AR, R, RSP. Every output is a register or decodes only the state.
//  IDLE: req_ready=1. On accept, latch addr/size/signed and clear the counter.
//   - Misaligned request: size 11; half with addr[0]=1; word with addr[1:0]!=0.
//     Go to RSP with rsp_err=1, rsp_to=0, rsp_data=0. No bus activity.
//   - Otherwise go to AR. arvalid=1 from the next cycle.
//  AR: arvalid=1 and araddr stays stable until arready. On arready go to R, arvalid=0.
//  R: rready=1. On rvalid, capture the lane and go to RSP.
//   - rsp_err=(rresp!=2'b00). rsp_to=0.
//   - Byte lane: rdata >> 8*addr[1:0], bits [7:0]. Half lane: rdata >> 16*addr[1],
//     bits [15:0]. Word: rdata unchanged.
//   - Extend to 32 bits using req_signed. On error, force rsp_data=0.
//  Timeout: the counter increments every cycle in AR and R.
//   When it reaches TIMEOUT, go to RSP with rsp_err=1, rsp_to=1, rsp_data=0.
//   arvalid and rready drop immediately.
//   The system treats a beat that arrives after a timeout as fatal; it is not drained here.
//  RSP: rsp_valid=1 and data is held until rsp_ready, then go to IDLE.
//   req_ready=0 in RSP, so back-to-back loads have a 1-cycle IDLE bubble.
//  Minimum latency, with arready=rvalid=1 always:
//   accept @T, arvalid @T+1, rready @T+2, rsp_valid @T+3.
//  The master never asserts arvalid and rready in the same cycle.
//  There is one outstanding read at most.
//  A slave that holds rvalid=1 permanently is fine: rvalid is sampled only in R.
// STRUCTURE
//  Shared defines header: the OKAY/EXOKAY/SLVERR/DECERR codes, the SIZE_B/H/W codes,
//  and the state encodings.
//  One sub-module, ysyx_25040129_load_ext: combinational lane select plus sign/zero
//  extension (addr[1:0], size, signed, rdata -> data). The FSM and counter stay in the top.
// TESTING
//  1 Word load from 0xa000_0048; slave arready=rvalid=1, rdata=0x1234_5678, OKAY
//    -> rsp_valid at T+3, rsp_data=0x1234_5678, rsp_err=0.
//  2 Byte loads, addr[1:0]=3, rdata=0x80xx_xxxx -> signed: 0xffff_ff80.
//    Unsigned: 0x0000_0080. Half with addr=..2, rdata=0x8001_xxxx,
//    signed -> 0xffff_8001.
//  3 Word at addr 0x...2, and a size=11 request -> rsp_err=1, rsp_to=0, rsp_data=0.
//    arvalid never rises.
//  4 arready delayed 5 cycles, then rvalid delayed 3 with rresp=2'b10
//    -> araddr stable throughout, rsp_err=1, rsp_data=0.
//  5 Slave never asserts rvalid (TIMEOUT=8) -> rsp_err=1, rsp_to=1 exactly 8 cycles
//    after accept. rready drops.
//  6 rst pulled low while in R, then released -> all outputs at reset values,
//    req_ready=1. The next load completes normally.
//    Also: hold rsp_ready=0 for 4 cycles -> rsp_valid/rsp_data stable, req_ready=0.

Source files
------------

// File: rtl/ysyx_25040129_lsu_rd_master_pkg.sv
// Shared bus response codes, load size codes and FSM encoding for the LSU read master.
package ysyx_25040129_lsu_rd_master_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

    // The illegal size code is reported the same way as a misaligned access.
    function automatic logic misaligned(input logic [1:0] off, input logic [1:0] size);
        logic bad;
        bad = 1'b1;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = off[0];
            SIZE_W:  bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ysyx_25040129_load_ext.sv
// Lane select and sign/zero extension of a 32-bit read beat for byte, half and word loads.
module ysyx_25040129_load_ext
    import ysyx_25040129_lsu_rd_master_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[7:0];
        case (off)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = off[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = rdata;
        case (size)
            SIZE_B:  data = {{24{sext & byte_lane[7]}}, byte_lane};
            SIZE_H:  data = {{16{sext & half_lane[15]}}, half_lane};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/ysyx_25040129_lsu_rd_master.sv
// LSU read-channel master: one outstanding load, alignment check, AR/R sequencing,
// lane extraction and a cycle timeout against silent devices.
module ysyx_25040129_lsu_rd_master
    import ysyx_25040129_lsu_rd_master_pkg::*;
#(
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        rsp_to,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready
);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [TO_W-1:0] cnt;
    logic [31:0] ext_data;
    logic        req_bad;
    logic        to_hit;
    logic        r_err;

    // The counter reads k-1 in the k-th cycle after accept; firing at TIMEOUT-2
    // puts the response exactly TIMEOUT cycles after the accept.
    assign to_hit  = (cnt == TO_W'(TIMEOUT - 2));
    assign req_bad = misaligned(req_addr[1:0], req_size);
    assign r_err   = (rresp != RESP_OKAY);

    assign req_ready = (state == ST_IDLE);
    assign arvalid   = (state == ST_AR);
    assign rready    = (state == ST_R);
    assign rsp_valid = (state == ST_RSP);

    ysyx_25040129_load_ext u_ext (
        .off   (araddr[1:0]),
        .size  (size_q),
        .sext  (signed_q),
        .rdata (rdata),
        .data  (ext_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Timeout wins over a late arready, but a beat arriving in the last R cycle is kept.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req_valid) state_nxt = req_bad ? ST_RSP : ST_AR;
            ST_AR: begin
                if (to_hit)       state_nxt = ST_RSP;
                else if (arready) state_nxt = ST_R;
            end
            ST_R:    if (rvalid || to_hit) state_nxt = ST_RSP;
            ST_RSP:  if (rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            araddr   <= '0;
            size_q   <= SIZE_B;
            signed_q <= 1'b0;
            cnt      <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            rsp_to   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        araddr   <= req_addr;
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        cnt      <= '0;
                        if (req_bad) begin
                            rsp_data <= '0;
                            rsp_err  <= 1'b1;
                            rsp_to   <= 1'b0;
                        end
                    end
                end
                ST_AR: begin
                    cnt <= cnt + TO_W'(1);
                    if (to_hit) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                        rsp_to   <= 1'b1;
                    end
                end
                ST_R: begin
                    cnt <= cnt + TO_W'(1);
                    if (rvalid) begin
                        rsp_data <= r_err ? 32'd0 : ext_data;
                        rsp_err  <= r_err;
                        rsp_to   <= 1'b0;
                    end else if (to_hit) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                        rsp_to   <= 1'b1;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b0;
                        rsp_to   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
